// File: rtl/video_timing_pkg.sv
// Shared types for the video timing generator: per-mode timing record,
// the four-entry mode table and helpers that derive line/frame totals.
package video_timing_pkg;

  localparam int TW = 16;

  typedef enum logic [1:0] {
    MODE_640X480   = 2'd0,
    MODE_800X600   = 2'd1,
    MODE_1280X720  = 2'd2,
    MODE_1920X1080 = 2'd3
  } video_mode_e;

  typedef struct packed {
    logic [TW-1:0] h_active;
    logic [TW-1:0] h_fp;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_bp;
    logic [TW-1:0] v_active;
    logic [TW-1:0] v_fp;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_bp;
    logic          sync_pos;
  } timing_t;

  typedef timing_t [0:3] mode_table_t;

  localparam mode_table_t MODE_TABLE = '{
    '{h_active: 16'd640,  h_fp: 16'd16,  h_sync: 16'd96,  h_bp: 16'd48,
      v_active: 16'd480,  v_fp: 16'd10,  v_sync: 16'd2,   v_bp: 16'd33,  sync_pos: 1'b0},
    '{h_active: 16'd800,  h_fp: 16'd40,  h_sync: 16'd128, h_bp: 16'd88,
      v_active: 16'd600,  v_fp: 16'd1,   v_sync: 16'd4,   v_bp: 16'd23,  sync_pos: 1'b1},
    '{h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40,  h_bp: 16'd220,
      v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,   v_bp: 16'd20,  sync_pos: 1'b1},
    '{h_active: 16'd1920, h_fp: 16'd88,  h_sync: 16'd44,  h_bp: 16'd148,
      v_active: 16'd1080, v_fp: 16'd4,   v_sync: 16'd5,   v_bp: 16'd36,  sync_pos: 1'b1}
  };

  function automatic logic [31:0] h_total(timing_t t);
    return 32'(t.h_active) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
  endfunction

  function automatic logic [31:0] v_total(timing_t t);
    return 32'(t.v_active) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Video timing bundle: requested mode in, sync/position/strobe outputs back.
interface video_timing_if #(
  parameter int HW = 12,
  parameter int VW = 11
);
  logic [1:0]    mode;
  logic          hsync;
  logic          vsync;
  logic          visible;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [1:0]    mode_active;

  modport master (
    input  mode,
    output hsync, vsync, visible, x, y, line_start, frame_start, mode_active
  );

  modport slave (
    output mode,
    input  hsync, vsync, visible, x, y, line_start, frame_start, mode_active
  );
endinterface

// File: rtl/video_mode_table.sv
// Combinational lookup from a timing mode code to its timing record.
module video_mode_table
  import video_timing_pkg::*;
#(
  parameter mode_table_t TABLE = MODE_TABLE
) (
  input  logic [1:0] mode,
  output timing_t    timing
);

  always_comb begin
    timing = TABLE[0];
    case (mode)
      MODE_640X480:   timing = TABLE[0];
      MODE_800X600:   timing = TABLE[1];
      MODE_1280X720:  timing = TABLE[2];
      MODE_1920X1080: timing = TABLE[3];
      default:        timing = TABLE[0];
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters for the active mode plus one
// registered output stage; mode switches only between frames.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          HW    = 12,
  parameter int          VW    = 11,
  parameter mode_table_t TABLE = MODE_TABLE
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vid
);

  for (genvar i = 0; i < 4; i++) begin : g_fit
    if ((h_total(TABLE[i]) > 32'(2**HW)) || (v_total(TABLE[i]) > 32'(2**VW))) begin : g_err
      $error("video_timing_gen: mode table entry does not fit the counter width");
    end
  end

  timing_t       cur_s;
  timing_t       req_s;
  logic          unused_req_s;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          visible_q, visible_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [1:0]    mode_active_q, mode_active_d;

  logic [31:0]   h_pos_s, v_pos_s;
  logic [31:0]   hs_start_s, vs_start_s;
  logic          h_last_s, v_last_s;

  // cur_s drives counting/decoding; req_s only supplies the reset sync level
  video_mode_table #(.TABLE(TABLE)) u_cur_table (.mode(mode_q),   .timing(cur_s));
  video_mode_table #(.TABLE(TABLE)) u_req_table (.mode(vid.mode), .timing(req_s));

  assign unused_req_s = ^req_s;

  // next counter position and decode of the current position into outputs
  always_comb begin
    h_pos_s    = 32'(h_q);
    v_pos_s    = 32'(v_q);
    h_last_s   = (h_pos_s == (h_total(cur_s) - 32'd1));
    v_last_s   = (v_pos_s == (v_total(cur_s) - 32'd1));
    hs_start_s = 32'(cur_s.h_active) + 32'(cur_s.h_fp);
    vs_start_s = 32'(cur_s.v_active) + 32'(cur_s.v_fp);

    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    if (h_last_s) begin
      h_d = '0;
      if (v_last_s) begin
        v_d    = '0;
        mode_d = vid.mode;
      end else begin
        v_d    = v_q + VW'(1);
        mode_d = mode_q;
      end
    end else begin
      h_d = h_q + HW'(1);
    end

    visible_d = (h_pos_s < 32'(cur_s.h_active)) && (v_pos_s < 32'(cur_s.v_active));
    hsync_d   = ((h_pos_s >= hs_start_s) && (h_pos_s < (hs_start_s + 32'(cur_s.h_sync))))
                ? cur_s.sync_pos : ~cur_s.sync_pos;
    vsync_d   = ((v_pos_s >= vs_start_s) && (v_pos_s < (vs_start_s + 32'(cur_s.v_sync))))
                ? cur_s.sync_pos : ~cur_s.sync_pos;
    x_d           = h_q;
    y_d           = v_q;
    line_start_d  = (h_q == '0);
    frame_start_d = (h_q == '0) && (v_q == '0);
    mode_active_d = mode_q;
  end

  // counters, active mode and the output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      mode_q        <= vid.mode;
      hsync_q       <= ~req_s.sync_pos;
      vsync_q       <= ~req_s.sync_pos;
      visible_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      mode_active_q <= vid.mode;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      mode_q        <= mode_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      mode_active_q <= mode_active_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.visible     = visible_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.mode_active = mode_active_q;

endmodule
